// File: rtl/enc_pkg.sv
// Shared definitions for the encoder_8x3_drain slice: state encoding, default
// width and small helpers for index width and single-bit detection.
package enc_pkg;

  localparam int DEF_IN_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ZBEAT = 2'd2;

  function automatic int out_w_of(input int in_w);
    return $clog2(in_w);
  endfunction

  // True when at most one bit is set; callers zero-extend vectors up to 64 bits.
  function automatic logic onehot_or_zero(input logic [63:0] vec);
    return (vec & (vec - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/encoder_8x3_drain_ffs_comb.sv
// Combinational find-first-set over a request vector; LSB_FIRST selects
// whether the lowest or the highest set bit wins.
module ffs_comb
  import enc_pkg::*;
#(
  parameter int  IN_W      = DEF_IN_W,
  parameter bit  LSB_FIRST = 1'b0,
  localparam int OUT_W     = out_w_of(IN_W)
) (
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx = '0;
    any = |vec;
    if (LSB_FIRST) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder_8x3_drain.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits one index per
// beat. Optional build macro ENC_LSB_FIRST_EN drains lowest set bit first.
module encoder_8x3_drain
  import enc_pkg::*;
#(
  parameter int  IN_W      = DEF_IN_W,
  parameter int  ZERO_EMIT = 1,
  localparam int OUT_W     = out_w_of(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             zero
);

`ifdef ENC_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic [IN_W-1:0]  pend_q, pend_d;
  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] ffs_idx;
  logic             pend_any;

  ffs_comb #(
    .IN_W      (IN_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_ffs (
    .vec (pend_q),
    .idx (ffs_idx),
    .any (pend_any)
  );

  // Outputs depend only on registered state and en, never on data_in/in_valid.
  always_comb begin
    in_ready  = en && (state_q == IDLE);
    out_valid = en && ((state_q == DRAIN) || (state_q == ZBEAT));
    y_out     = '0;
    out_last  = 1'b0;
    zero      = 1'b0;
    if (out_valid) begin
      if (state_q == DRAIN) begin
        y_out    = ffs_idx;
        out_last = onehot_or_zero(64'(pend_q));
      end else begin
        out_last = 1'b1;
        zero     = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pend_d = data_in;
          if (data_in != '0)       state_d = DRAIN;
          else if (ZERO_EMIT != 0) state_d = ZBEAT;
        end
      end
      DRAIN: begin
        if (en && !pend_any) begin
          state_d = IDLE;
        end else if (out_valid && out_ready) begin
          pend_d = pend_q & ~(IN_W'(1) << ffs_idx);
          if (out_last) state_d = IDLE;
        end
      end
      ZBEAT: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_encoder_8x3_drain.sv
// Randomised and directed bench for encoder_8x3_drain; expected beats come from
// a queue built by scanning each vector's set bits in drain order.
module tb_encoder_8x3_drain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] y_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       zero;

  logic       en2;
  logic [7:0] data2;
  logic       in_valid2;
  logic       in_ready2;
  logic [2:0] y_out2;
  logic       out_valid2;
  logic       out_ready2;
  logic       out_last2;
  logic       zero2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_8x3_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero      (zero)
  );

  encoder_8x3_drain #(.ZERO_EMIT(0)) dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en2),
    .data_in   (data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .y_out     (y_out2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_last  (out_last2),
    .zero      (zero2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list of indices in drain order; a zero vector yields one index-0 beat.
  task automatic build_expect(input logic [7:0] vec, output int q[$]);
    q = {};
`ifdef ENC_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) if (vec[i]) q.push_back(i);
`else
    for (int i = 7; i >= 0; i--) if (vec[i]) q.push_back(i);
`endif
    if (vec == 8'h00) q.push_back(0);
  endtask

  task automatic run_vec(input logic [7:0] vec, input int stall_first, input bit rand_ready,
                         input bit rand_en, input int gap_after);
    int q[$];
    int cyc;
    int accepted;
    int gap_left;
    build_expect(vec, q);
    @(negedge clk);
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; data_in = vec;
    #1 check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 8'($urandom);
    cyc = 0; accepted = 0; gap_left = 0;
    while (q.size() > 0 && cyc < 300) begin
      if (gap_left > 0) begin
        en = 1'b0; gap_left--;
      end else begin
        en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (cyc < stall_first)  out_ready = 1'b0;
      else if (rand_ready)    out_ready = 1'($urandom_range(0, 1));
      else                    out_ready = 1'b1;
      #1;
      if (!en) begin
        check("en_low_valid", out_valid, 0);
        check("en_low_ready", in_ready, 0);
        check("en_low_y", y_out, 0);
        check("en_low_last", out_last, 0);
      end else begin
        check("beat_valid", out_valid, 1);
        check("beat_y", y_out, q[0]);
        check("beat_last", out_last, q.size() == 1);
        check("beat_zero", zero, vec == 8'h00);
        check("drain_in_ready", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          accepted++;
          if (accepted == gap_after) gap_left = 2;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) check("drain_timeout", 1, 0);
    en = 1'b1; out_ready = 1'b0;
    #1;
    check("after_last_valid", out_valid, 0);
    check("after_last_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; data_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    en2 = 1'b1; data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_last", out_last, 0);
    check("rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    run_vec(8'b1000_0001, 0, 1'b0, 1'b0, -1);
    run_vec(8'b0010_0100, 3, 1'b0, 1'b0, -1);
    run_vec(8'h00,        0, 1'b0, 1'b0, -1);

    // Zero vector is dropped when zero-beat emission is disabled.
    @(negedge clk);
    in_valid2 = 1'b1; data2 = 8'h00;
    #1 check("nz_capture_ready", in_ready2, 1);
    @(negedge clk);
    in_valid2 = 1'b0; data2 = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nz_no_beat", out_valid2, 0);
      check("nz_ready", in_ready2, 1);
      @(negedge clk);
    end

    run_vec(8'hFF, 0, 1'b0, 1'b0, 3);

    // Asynchronous reset in the middle of draining 8'hF0.
    @(negedge clk);
    en = 1'b1; in_valid = 1'b1; data_in = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_mid_first_valid", out_valid, 1);
`ifdef ENC_LSB_FIRST_EN
    check("rst_mid_first_y", y_out, 4);
`else
    check("rst_mid_first_y", y_out, 7);
`endif
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_y", y_out, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    #1 check("no_stale_beat", out_valid, 0);
    run_vec(8'h02, 0, 1'b0, 1'b0, -1);

    run_vec(8'b1000_1010, 0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_vec(v, int'($urandom_range(0, 2)), 1'b1, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
